// File: rtl/ad_bus_pkg.sv
// Shared types and constants for the multiplexed AD bus sequencer.
package ad_bus_pkg;
    localparam int BUS_W     = 8;
    localparam int T_SU_DEF  = 4;
    localparam int T_PW_DEF  = 14;
    localparam int T_HLD_DEF = 2;
    localparam int T_GAP_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_A_SU, S_A_PW, S_A_HLD, S_D_SU, S_D_PW, S_D_HLD, S_GAP
    } state_t;

    // All bus-facing outputs, registered together as one word.
    typedef struct packed {
        logic             cs_n;
        logic             rd_n;
        logic             wr_n;
        logic             ad_sel;
        logic             ad_oe;
        logic [BUS_W-1:0] ad_out;
    } bus_t;

    // Bus at rest: chip deselected, strobes high, driver off.
    localparam bus_t BUS_RST = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                 ad_sel: 1'b0, ad_oe: 1'b0, ad_out: '0};
endpackage

// File: rtl/ad_bus_if.sv
// Host request/ack signals plus the multiplexed AD bus pins.
interface ad_bus_if;
    import ad_bus_pkg::*;

    logic             wr_req_i;
    logic             rd_req_i;
    logic [BUS_W-1:0] addr_i;
    logic [BUS_W-1:0] wdata_i;
    logic             ack_o;
    logic             ack_wr_o;
    logic             done_o;
    logic [BUS_W-1:0] rdata_o;
    logic             busy_o;
    logic             cs_n_o;
    logic             rd_n_o;
    logic             wr_n_o;
    logic             ad_sel_o;
    logic [BUS_W-1:0] ad_out_o;
    logic             ad_oe_o;
    logic [BUS_W-1:0] ad_in_i;

    // Sequencer side: it masters the AD bus.
    modport master (
        input  wr_req_i, rd_req_i, addr_i, wdata_i, ad_in_i,
        output ack_o, ack_wr_o, done_o, rdata_o, busy_o,
               cs_n_o, rd_n_o, wr_n_o, ad_sel_o, ad_out_o, ad_oe_o
    );

    // Environment side: host plus the attached peripheral.
    modport slave (
        output wr_req_i, rd_req_i, addr_i, wdata_i, ad_in_i,
        input  ack_o, ack_wr_o, done_o, rdata_o, busy_o,
               cs_n_o, rd_n_o, wr_n_o, ad_sel_o, ad_out_o, ad_oe_o
    );
endinterface

// File: rtl/ad_bus_sequencer_timer.sv
// 4-bit loadable down-counter that times each bus phase.
module phase_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);
    logic [3:0] cnt;

    // Load on phase entry, then count down and park at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             cnt <= 4'd0;
        else if (load)           cnt <= load_val;
        else if (cnt != 4'd0)    cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);
endmodule

// File: rtl/ad_bus_sequencer.sv
// Sequences one address phase and one data phase on a multiplexed AD bus
// per accepted request, with round-robin arbitration between write and read.
module ad_bus_sequencer
    import ad_bus_pkg::*;
#(
    parameter int T_SU  = T_SU_DEF,
    parameter int T_PW  = T_PW_DEF,
    parameter int T_HLD = T_HLD_DEF,
    parameter int T_GAP = T_GAP_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    ad_bus_if.master bus
);
    state_t           state, state_nxt;
    logic             is_wr, is_wr_nxt;   // current direction, doubles as last-served
    logic [BUS_W-1:0] addr_q, addr_nxt;
    logic [BUS_W-1:0] data_q, data_nxt;
    logic             accept, grant_wr;
    logic             tmr_load, tmr_zero;
    logic [3:0]       tmr_val;
    bus_t             bus_nxt, bus_q;
    logic             ack_q, done_q, busy_q;
    logic [BUS_W-1:0] rdata_q;

    phase_timer u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State and latched transaction context.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= S_IDLE;
            is_wr  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            is_wr  <= is_wr_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    // Next state, arbitration and phase-timer reload.
    always_comb begin
        state_nxt = state;
        is_wr_nxt = is_wr;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        accept    = 1'b0;
        // Write wins unless both are pending and write was served last.
        grant_wr  = bus.wr_req_i && (!bus.rd_req_i || !is_wr);
        case (state)
            S_IDLE: if (bus.wr_req_i || bus.rd_req_i) begin
                accept    = 1'b1;
                state_nxt = S_A_SU;
                is_wr_nxt = grant_wr;
                addr_nxt  = bus.addr_i;
                data_nxt  = bus.wdata_i;
            end
            S_A_SU:  if (tmr_zero) state_nxt = S_A_PW;
            S_A_PW:  if (tmr_zero) state_nxt = S_A_HLD;
            S_A_HLD: if (tmr_zero) state_nxt = S_D_SU;
            S_D_SU:  if (tmr_zero) state_nxt = S_D_PW;
            S_D_PW:  if (tmr_zero) state_nxt = S_D_HLD;
            S_D_HLD: if (tmr_zero) state_nxt = S_GAP;
            S_GAP:   if (tmr_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        tmr_load = (state_nxt != state);
        case (state_nxt)
            S_A_SU, S_D_SU:   tmr_val = 4'(T_SU - 1);
            S_A_PW, S_D_PW:   tmr_val = 4'(T_PW - 1);
            S_A_HLD, S_D_HLD: tmr_val = 4'(T_HLD - 1);
            S_GAP:            tmr_val = 4'(T_GAP - 1);
            default:          tmr_val = 4'd0;
        endcase
    end

    // Bus outputs decoded from the upcoming state so the registers line up with it.
    always_comb begin
        bus_nxt = BUS_RST;
        case (state_nxt)
            S_A_SU, S_A_PW, S_A_HLD: begin
                bus_nxt.cs_n   = 1'b0;
                bus_nxt.ad_oe  = 1'b1;
                bus_nxt.ad_out = addr_nxt;
                bus_nxt.wr_n   = (state_nxt != S_A_PW);
            end
            S_D_SU, S_D_PW, S_D_HLD: begin
                bus_nxt.cs_n   = 1'b0;
                bus_nxt.ad_sel = 1'b1;
                bus_nxt.ad_oe  = is_wr_nxt;
                bus_nxt.ad_out = is_wr_nxt ? data_nxt : '0;
                bus_nxt.wr_n   = !(is_wr_nxt && state_nxt == S_D_PW);
                bus_nxt.rd_n   = !(!is_wr_nxt && state_nxt == S_D_PW);
            end
            default: ;
        endcase
    end

    // Output registers; read data is captured at the close of the read strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_q   <= BUS_RST;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            bus_q  <= bus_nxt;
            ack_q  <= accept;
            done_q <= (state_nxt == S_GAP) && (state != S_GAP);
            busy_q <= (state_nxt != S_IDLE);
            if (state == S_D_PW && tmr_zero && !is_wr)
                rdata_q <= bus.ad_in_i;
        end
    end

    assign bus.cs_n_o   = bus_q.cs_n;
    assign bus.rd_n_o   = bus_q.rd_n;
    assign bus.wr_n_o   = bus_q.wr_n;
    assign bus.ad_sel_o = bus_q.ad_sel;
    assign bus.ad_oe_o  = bus_q.ad_oe;
    assign bus.ad_out_o = bus_q.ad_out;
    assign bus.ack_o    = ack_q;
    assign bus.ack_wr_o = is_wr;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = busy_q;
    assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_ad_bus_sequencer.sv
// Directed bench for ad_bus_sequencer at default timing (44-cycle transactions).
module tb_ad_bus_sequencer;
    import ad_bus_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ad_bus_if bus ();

    ad_bus_sequencer #(.T_SU(4), .T_PW(14), .T_HLD(2), .T_GAP(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {ack, done, busy, cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out}
    function automatic logic [15:0] obs_vec();
        return {bus.ack_o, bus.done_o, bus.busy_o, bus.cs_n_o, bus.rd_n_o,
                bus.wr_n_o, bus.ad_sel_o, bus.ad_oe_o, bus.ad_out_o};
    endfunction

    // Bus protocol rules, checked every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n)
            chk("bus_rules",
                {29'd0, (!bus.rd_n_o && !bus.wr_n_o),
                        (bus.cs_n_o && (!bus.rd_n_o || !bus.wr_n_o)),
                        (bus.ad_oe_o && !bus.rd_n_o)}, 32'd0);
    end

    // Called at the sample point of the IDLE cycle whose closing edge accepts;
    // checks cycles k=0 (first A_SU) .. 44 (IDLE again).
    task automatic run_txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rd_exp, input logic [1:0] req_after,
                           input logic [7:0] addr_after, input string tag);
        logic [15:0] exp, msk;
        bit pw;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            exp = '0;
            msk = 16'hFFFF;
            exp[15] = (k == 0);
            exp[14] = (k == 40);
            exp[13] = (k < 44);
            if (k < 20) begin
                exp[11] = 1'b1;
                exp[10] = !(k >= 4 && k < 18);
                exp[8]  = 1'b1;
                exp[7:0] = a;
            end else if (k < 40) begin
                pw = (k >= 24 && k < 38);
                exp[9] = 1'b1;
                if (wr) begin
                    exp[11] = 1'b1;
                    exp[10] = !pw;
                    exp[8]  = 1'b1;
                    exp[7:0] = d;
                end else begin
                    exp[11] = !pw;
                    exp[10] = 1'b1;
                    msk[7:0] = 8'h00;
                end
            end else begin
                exp[12] = 1'b1;
                exp[11] = 1'b1;
                exp[10] = 1'b1;
                msk[9]   = 1'b0;
                msk[7:0] = 8'h00;
            end
            chk($sformatf("%s_k%0d", tag, k), {16'd0, obs_vec() & msk}, {16'd0, exp});
            if (k == 0) begin
                chk($sformatf("%s_ackwr", tag), {31'd0, bus.ack_wr_o}, {31'd0, wr});
                {bus.wr_req_i, bus.rd_req_i} = req_after;
                bus.addr_i = addr_after;
            end
            if (k == 40) begin
                chk($sformatf("%s_donewr", tag), {31'd0, bus.ack_wr_o}, {31'd0, wr});
                chk($sformatf("%s_rdata", tag), {24'd0, bus.rdata_o}, {24'd0, rd_exp});
            end
            bus.ad_in_i = (k >= 24 && k < 38) ? 8'h3C : 8'hA5;
        end
    endtask

    initial begin
        logic seen;
        bus.wr_req_i = 1'b0;
        bus.rd_req_i = 1'b0;
        bus.addr_i   = 8'h00;
        bus.wdata_i  = 8'h00;
        bus.ad_in_i  = 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec", {16'd0, obs_vec()}, 32'h1C00);
        chk("rst_rdata", {24'd0, bus.rdata_o}, 32'd0);
        chk("rst_ackwr", {31'd0, bus.ack_wr_o}, 32'd0);

        // Both requests together right out of reset: write first, then read.
        rst_n = 1'b1;
        bus.wr_req_i = 1'b1;
        bus.rd_req_i = 1'b1;
        bus.addr_i   = 8'h2A;
        bus.wdata_i  = 8'h55;
        run_txn(1'b1, 8'h2A, 8'h55, 8'h00, 2'b01, 8'h0C, "wr1");
        // Read; a write request raised mid-transaction must wait for IDLE.
        run_txn(1'b0, 8'h0C, 8'h55, 8'h3C, 2'b10, 8'h91, "rd1");
        // Write held high: back-to-back writes with 4 GAP + 1 IDLE between.
        run_txn(1'b1, 8'h91, 8'h55, 8'h3C, 2'b10, 8'h91, "wr2");
        run_txn(1'b1, 8'h91, 8'h55, 8'h3C, 2'b10, 8'h91, "wr3");

        // Third chained write, aborted by reset in its 5th A_PW cycle.
        @(posedge clk); #1;
        chk("ab_ack", {31'd0, bus.ack_o}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("ab_pw", {30'd0, bus.cs_n_o, bus.wr_n_o}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ab_async", {16'd0, obs_vec()}, 32'h1C00);
        chk("ab_rdata", {24'd0, bus.rdata_o}, 32'd0);
        bus.wr_req_i = 1'b0;
        bus.rd_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            seen = seen | bus.done_o | bus.busy_o | bus.ack_o;
        end
        chk("ab_quiet", {31'd0, seen}, 32'd0);

        // Last-served returns to read on reset, so write wins again.
        bus.wr_req_i = 1'b1;
        bus.rd_req_i = 1'b1;
        bus.addr_i   = 8'h81;
        bus.wdata_i  = 8'h7E;
        run_txn(1'b1, 8'h81, 8'h7E, 8'h00, 2'b00, 8'h00, "wr4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_bus_sequencer.md
AD_BUS_SEQUENCER -- requirements
Module: ad_bus_sequencer

Interface
REQ-001 Parameter T_SU, default 4, sets the setup cycles before each strobe (1..15).
REQ-002 Parameter T_PW, default 14, sets the strobe low width in cycles (1..15).
REQ-003 Parameter T_HLD, default 2, sets the hold cycles after each strobe (1..15).
REQ-004 Parameter T_GAP, default 4, sets the bus-idle cycles between transactions (1..15).
REQ-005 Port: clk_i  in  1  single clock, rising edge.
REQ-006 Port: rst_ni  in  1  reset; asynchronous, active-low.
REQ-007 Port: wr_req_i  in  1  write request, level.
REQ-008 Port: rd_req_i  in  1  read request, level.
REQ-009 Port: addr_i  in  8  register address, sampled at accept.
REQ-010 Port: wdata_i  in  8  write data, sampled at accept.
REQ-011 Port: ack_o  out  1  one-cycle pulse, request accepted.
REQ-012 Port: ack_wr_o  out  1  qualifies ack_o/done_o: 1 = write, 0 = read.
REQ-013 Port: done_o  out  1  one-cycle pulse, transaction complete.
REQ-014 Port: rdata_o  out  8  last read data.
REQ-015 Port: busy_o  out  1  high in every state except IDLE.
REQ-016 Port: cs_n_o, rd_n_o, wr_n_o  out  1 each  bus strobes, active-low.
REQ-017 Port: ad_sel_o  out  1  0 = address phase, 1 = data phase.
REQ-018 Port: ad_out_o  out  8  driven AD value; ad_oe_o  out  1  AD driver enable.
REQ-019 Port: ad_in_i  in  8  AD bus read value.

Function
REQ-020 FSM states: IDLE, A_SU, A_PW, A_HLD, D_SU, D_PW, D_HLD, GAP; each timed state lasts exactly its parameter count in cycles.
REQ-021 In IDLE with any request high at a clock edge: ack_o pulses the next cycle, addr/wdata/direction are latched, and the state becomes A_SU.
REQ-022 Simultaneous requests use round-robin: the grant goes to the direction not served last; after reset, write has priority.
REQ-023 A_SU/A_PW/A_HLD: cs_n=0, ad_sel=0, ad_oe=1, ad_out=latched addr; wr_n=0 only in A_PW.
REQ-024 D_SU/D_PW/D_HLD: cs_n=0, ad_sel=1; on write, ad_oe=1 and ad_out=latched data, with wr_n=0 only in D_PW.
REQ-025 On read in D_*: ad_oe=0 and rd_n=0 only in D_PW; rdata_o captures ad_in_i on the last D_PW cycle and holds until the next read.
REQ-026 In the first GAP cycle: done_o=1; throughout GAP: cs_n=1, ad_oe=0, strobes high.
REQ-027 Transaction length from the first A_SU cycle to IDLE re-entry = 2*(T_SU+T_PW+T_HLD)+T_GAP, which is 44 cycles at defaults.
REQ-028 Requests are ignored while busy_o=1; a request still high in IDLE starts a new transaction.
REQ-029 rd_n and wr_n are never low together; no strobe is low while cs_n=1; all bus outputs are registered (glitch-free).
REQ-030 The phase counter loads the parameter minus one on state entry and counts down to zero; no wrap-around occurs.

Reset
REQ-031 While rst_ni=0, the block immediately holds: cs_n/rd_n/wr_n=1, ad_oe=0, ad_sel=0, ad_out=0, ack/done/busy=0, rdata_o=0, state IDLE, last-served=read.
REQ-032 Reset mid-transaction aborts it without a done_o pulse; latched requests are discarded.
REQ-033 After rst_ni deasserts, the first request can be accepted on the first clock edge.

Structure
REQ-034 The package ad_bus_pkg holds the state enum, the default timing constants, and the 8-bit bus width constant.
REQ-035 One sub-module, phase_timer, provides a 4-bit loadable down-counter with a zero flag, instantiated once.

Verification
REQ-036 Write addr=0x2A, data=0x55 -> wr_n low for 14 cycles with ad_out=0x2A, then 14 cycles with ad_out=0x55; done_o occurs 40 cycles after the first A_SU cycle.
REQ-037 Read addr=0x0C with ad_in_i=0x3C during D_PW -> rd_n low for 14 cycles, ad_oe=0 in D_*, rdata_o=0x3C at done_o.
REQ-038 wr_req and rd_req raised together after reset -> write served first, then read after GAP; ack_wr_o = 1 then 0.
REQ-039 rst_ni pulled low in the 5th A_PW cycle -> all strobes go high asynchronously, no done_o, and busy_o=0.
REQ-040 wr_req held high continuously -> back-to-back writes with exactly 4 cs_n-high GAP cycles plus 1 IDLE cycle between them.
REQ-041 Assertions for the whole run -> never rd_n=wr_n=0; never a strobe low while cs_n=1; never ad_oe=1 while rd_n=0.
